arcade_input_cond: RTL

- Input conditioning stage sitting directly upstream of the bosconian core's player/coin inputs.
- Takes raw joystick-derived control bits from hps_io and performs four jobs: synchronisation, debouncing, SOCD cleaning of directions, and coin-pulse shaping with a small coin queue.
- Its outputs drive the core's coin1/coin2/start/up/down/left/right/fire ports directly.
- Runs on clk_sys, so the core samples arcade-like coin pulses regardless of how briefly or how often the button is pressed.

---
 rtl/arcade_input_cond.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_cond.sv
// Input conditioning for the arcade core: sync, debounce, SOCD cleaning,
// and coin pulse shaping with a small per-slot coin queue.
module arcade_input_cond #(
   parameter int DEBOUNCE_CYC = 90000,
   parameter int COIN_PULSE   = 1800000,
   parameter int COIN_GAP     = 1800000,
   parameter int QUEUE_MAX    = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       pause,
   input  logic [8:0] raw_in,
   output logic [3:0] dirs_out,
   output logic       fire_out,
   output logic       start1_out,
   output logic       start2_out,
   output logic       coin1_out,
   output logic       coin2_out,
   output logic [7:0] coin_total
);

   localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int TMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
   localparam int TW = (TMAX > 2) ? $clog2(TMAX) : 1;

   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [TW-1:0] T_PULSE = TW'(COIN_PULSE - 1);
   localparam logic [TW-1:0] T_GAP   = TW'(COIN_GAP - 1);
   localparam logic [2:0]    QMAX    = 3'(QUEUE_MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_GAP
   } coin_st_t;

   logic [8:0]    sync1;
   logic [8:0]    sync2;
   logic [8:0]    db;
   logic [DW-1:0] db_cnt [9];

   logic          up_c;
   logic          dn_c;
   logic          lf_c;
   logic          rt_c;

   logic [1:0]    db_q;
   logic [1:0]    coin_edge;
   logic [1:0]    coin_start;
   logic [1:0]    coin_o;
   logic [3:0]    q_nxt [2];
   logic [2:0]    q_sat [2];
   logic [2:0]    q     [2];
   logic [TW-1:0] tmr   [2];
   coin_st_t      st    [2];

   // two-flop synchroniser on every raw control bit
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   // per-bit debounce: accept a new level once it has held long enough
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         db <= '0;
         for (int i = 0; i < 9; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 9; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // opposing directions cancel to neutral
   always_comb begin
      up_c = db[3] & ~db[2];
      dn_c = db[2] & ~db[3];
      lf_c = db[1] & ~db[0];
      rt_c = db[0] & ~db[1];
   end

   // register player controls so they share one cycle of alignment
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dirs_out   <= '0;
         fire_out   <= 1'b0;
         start1_out <= 1'b0;
         start2_out <= 1'b0;
      end else begin
         dirs_out   <= {up_c, dn_c, lf_c, rt_c};
         fire_out   <= db[4];
         start1_out <= db[5];
         start2_out <= db[6];
      end
   end

   // previous debounced coin levels for rising-edge detection
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) db_q <= '0;
      else       db_q <= db[8:7];
   end

   // coin edges, pulse starts and saturating queue next-state
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         coin_edge[s]  = db[7+s] & ~db_q[s];
         coin_start[s] = (st[s] == S_IDLE) & ~pause &
                         (coin_edge[s] | (q[s] != 3'd0));
         q_nxt[s] = {1'b0, q[s]} + {3'b000, coin_edge[s]}
                  - {3'b000, coin_start[s]};
         q_sat[s] = (q_nxt[s] > {1'b0, QMAX}) ? QMAX : q_nxt[s][2:0];
      end
   end

   // per-slot coin FSM: idle, timed pulse high, timed gap low
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < 2; s++) begin
            st[s]     <= S_IDLE;
            tmr[s]    <= '0;
            q[s]      <= '0;
            coin_o[s] <= 1'b0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            q[s] <= q_sat[s];
            unique case (st[s])
               S_IDLE: begin
                  if (coin_start[s]) begin
                     st[s]     <= S_PULSE;
                     tmr[s]    <= T_PULSE;
                     coin_o[s] <= 1'b1;
                  end
               end
               S_PULSE: begin
                  if (!pause) begin
                     if (tmr[s] == '0) begin
                        st[s]     <= S_GAP;
                        tmr[s]    <= T_GAP;
                        coin_o[s] <= 1'b0;
                     end else begin
                        tmr[s] <= tmr[s] - TW'(1);
                     end
                  end
               end
               S_GAP: begin
                  if (!pause) begin
                     if (tmr[s] == '0) st[s]  <= S_IDLE;
                     else              tmr[s] <= tmr[s] - TW'(1);
                  end
               end
               default: begin
                  st[s]     <= S_IDLE;
                  coin_o[s] <= 1'b0;
               end
            endcase
         end
      end
   end

   // running count of pulses issued across both slots
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) coin_total <= '0;
      else coin_total <= coin_total + {7'b0, coin_start[0]}
                                    + {7'b0, coin_start[1]};
   end

   assign coin1_out = coin_o[0];
   assign coin2_out = coin_o[1];

endmodule
